sd_audio_mixer_mc: RTL

- Parametrised successor to the single-channel 8-bit beeper/AY mixer.
- Mixes NCH offset-binary PCM channels into separate left/right sums, with per-channel 4-bit volume and L/R pan enables, plus an optional ear/spk/mic beeper level added to both sides.
- Saturates each sum to W bits and drives two first-order sigma-delta DACs (left, right), one bit per pin.
- Sits between the sound sources (AY/PSG, covox, beeper) and the audio output pins.

---
 rtl/sd_audio_pkg.sv | 30 +++
 rtl/sd_audio_mixer_mc_if.sv | 26 ++
 rtl/sd_audio_mixer_mc_dac1.sv | 32 +++
 rtl/sd_audio_mixer_mc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sd_audio_pkg.sv
// rtl/sd_audio_pkg.sv - shared types, beeper levels and clamp helper for the audio mixer
package sd_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_COMMIT = 2'd2
    } mix_state_e;

    // Indexed by {ear, spk, mic}; scaled up by W-8 bits for wider DACs.
    localparam logic signed [7:0] BEEP_LVL [0:7] = '{
        -8'sd96, -8'sd80, 8'sd48, 8'sd56, -8'sd92, -8'sd72, 8'sd100, 8'sd120
    };

    function automatic logic signed [31:0] clamp_signed(input logic signed [31:0] v,
                                                        input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sd_audio_mixer_mc_if.sv
// rtl/sd_audio_mixer_mc_if.sv - source-side and output-pin signals of the audio mixer
interface sd_audio_mixer_mc_if #(
    parameter int W   = 8,
    parameter int NCH = 3
);
    logic [NCH*W-1:0] ch_data;
    logic [NCH*4-1:0] ch_vol;
    logic [NCH*2-1:0] ch_pan;
    logic             beep_en;
    logic             ear;
    logic             spk;
    logic             mic;
    logic             audio_l;
    logic             audio_r;
    logic             sample_strobe;

    modport master (
        output ch_data, ch_vol, ch_pan, beep_en, ear, spk, mic,
        input  audio_l, audio_r, sample_strobe
    );

    modport slave (
        input  ch_data, ch_vol, ch_pan, beep_en, ear, spk, mic,
        output audio_l, audio_r, sample_strobe
    );
endinterface

// File: rtl/sd_audio_mixer_mc_dac1.sv
// rtl/sd_audio_mixer_mc_dac1.sv - first-order sigma-delta DAC, one output bit per clock
module sd_dac1 #(
    parameter int W = 8
) (
    input  logic         clkdac,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W+1:0] sigma_q, sigma_d;
    logic [W+1:0] delta_b;
    logic         dout_q, dout_d;

    // Feedback subtracts 2^W whenever the integrator MSB is set.
    always_comb begin
        delta_b = {sigma_q[W+1], sigma_q[W+1], {W{1'b0}}};
        sigma_d = {2'b00, din} + delta_b + sigma_q;
        dout_d  = sigma_q[W+1];
    end

    always_ff @(posedge clkdac) begin
        if (reset) begin
            sigma_q <= {2'b01, {W{1'b0}}};
            dout_q  <= 1'b0;
        end else begin
            sigma_q <= sigma_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/sd_audio_mixer_mc.sv
// rtl/sd_audio_mixer_mc.sv - NCH-channel PCM/beeper stereo mixer driving two sigma-delta DACs
module sd_audio_mixer_mc
    import sd_audio_pkg::*;
#(
    parameter int W   = 8,
    parameter int NCH = 3,
    parameter int DIV = 64
) (
    input  logic              clkdac,
    input  logic              reset,
    sd_audio_mixer_mc_if.slave aif
);
    localparam int ACC_W = W + 4 + $clog2(NCH + 1);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    if (DIV < NCH + 2) begin : g_bad_div
        $error("sd_audio_mixer_mc: DIV must be at least NCH+2");
    end
    if (W < 8 || W > 16 || NCH < 1 || NCH > 8) begin : g_bad_size
        $error("sd_audio_mixer_mc: W must be 8..16 and NCH 1..8");
    end

    logic [CNT_W-1:0]        count_q, count_d;
    mix_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NCH*W-1:0]        snap_data_q, snap_data_d;
    logic [NCH*4-1:0]        snap_vol_q, snap_vol_d;
    logic [NCH*2-1:0]        snap_pan_q, snap_pan_d;
    logic [W-1:0]            dac_in_l_q, dac_in_l_d, dac_in_r_q, dac_in_r_d;
    logic                    strobe_q, strobe_d;

    logic                    tick;
    logic signed [7:0]       beep_lvl;
    logic signed [W-1:0]     beep_w;
    logic [W-1:0]            cur_raw;
    logic signed [W-1:0]     cur_s;
    logic [3:0]              cur_vol;
    logic [1:0]              cur_pan;
    logic signed [W+4:0]     prod;
    logic signed [ACC_W-1:0] term, sum_l, sum_r;

    always_comb begin
        tick     = (count_q == CNT_W'(DIV - 1));
        count_d  = tick ? '0 : count_q + CNT_W'(1);

        beep_lvl = BEEP_LVL[{aif.ear, aif.spk, aif.mic}];
        beep_w   = W'(beep_lvl) <<< (W - 8);

        cur_raw  = snap_data_q[idx_q*W +: W];
        cur_s    = {~cur_raw[W-1], cur_raw[W-2:0]};
        cur_vol  = snap_vol_q[idx_q*4 +: 4];
        cur_pan  = snap_pan_q[idx_q*2 +: 2];
        prod     = (W+5)'(cur_s) * (W+5)'($signed({1'b0, cur_vol}));
        term     = ACC_W'(prod >>> 4);
        sum_l    = acc_l_q + (cur_pan[0] ? term : '0);
        sum_r    = acc_r_q + (cur_pan[1] ? term : '0);

        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        snap_data_d = snap_data_q;
        snap_vol_d  = snap_vol_q;
        snap_pan_d  = snap_pan_q;
        dac_in_l_d  = dac_in_l_q;
        dac_in_r_d  = dac_in_r_q;
        strobe_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    snap_data_d = aif.ch_data;
                    snap_vol_d  = aif.ch_vol;
                    snap_pan_d  = aif.ch_pan;
                    acc_l_d     = aif.beep_en ? ACC_W'(beep_w) : '0;
                    acc_r_d     = aif.beep_en ? ACC_W'(beep_w) : '0;
                    idx_d       = '0;
                    state_d     = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                if (idx_q == IDX_W'(NCH - 1)) begin
                    // Clamp the finished sums on the way into COMMIT so the
                    // new DAC word and the strobe appear together NCH+1 edges after tick.
                    dac_in_l_d = W'(clamp_signed(32'(sum_l), W)) ^ MID;
                    dac_in_r_d = W'(clamp_signed(32'(sum_r), W)) ^ MID;
                    strobe_d   = 1'b1;
                    state_d    = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkdac) begin
        if (reset) begin
            count_q     <= '0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            snap_data_q <= '0;
            snap_vol_q  <= '0;
            snap_pan_q  <= '0;
            dac_in_l_q  <= MID;
            dac_in_r_q  <= MID;
            strobe_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            snap_data_q <= snap_data_d;
            snap_vol_q  <= snap_vol_d;
            snap_pan_q  <= snap_pan_d;
            dac_in_l_q  <= dac_in_l_d;
            dac_in_r_q  <= dac_in_r_d;
            strobe_q    <= strobe_d;
        end
    end

    logic audio_l_w, audio_r_w;

    sd_dac1 #(.W(W)) u_dac_l (
        .clkdac (clkdac),
        .reset  (reset),
        .din    (dac_in_l_q),
        .dout   (audio_l_w)
    );

    sd_dac1 #(.W(W)) u_dac_r (
        .clkdac (clkdac),
        .reset  (reset),
        .din    (dac_in_r_q),
        .dout   (audio_r_w)
    );

    assign aif.audio_l       = audio_l_w;
    assign aif.audio_r       = audio_r_w;
    assign aif.sample_strobe = strobe_q;
endmodule
